ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same open-drain PS2_CLK/PS2_DAT pair the keyboard receiver listens on. It performs the clock-inhibit, request-to-send, bit shifting on device-generated clock edges, odd parity, stop bit and device acknowledge check. It sits beside the receiver in `top`, and its open-drain enables are combined at the pad with the receiver's inputs.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency; documentation only.
- `INHIBIT_CYCLES`, 5000, CLK cycles PS2_CLK is held low before the request-to-send (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 1_000_000, maximum CLK cycles without a device clock falling edge before abort (20 ms).

- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  command byte; captured on accept.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_ready`  out  1  high only in IDLE; accept = `tx_valid & tx_ready`.
- `ps2_clk_in`  in  1  raw PS2_CLK pad level (asynchronous).
- `ps2_dat_in`  in  1  raw PS2_DAT pad level (asynchronous).
- `ps2_clk_oe`  out  1  1 = drive PS2_CLK low; 0 = release (pull-up).
- `ps2_dat_oe`  out  1  1 = drive PS2_DAT low; 0 = release.
- `busy`  out  1  high in every state except IDLE.
- `tx_done`  out  1  one-cycle pulse: byte sent and device ACK seen.
- `tx_err`  out  1  one-cycle pulse: missing ACK or timeout.

## Operation
- Inputs pass through 2-FF synchronizers. `fall` = synced clk previous 1, current 0.
- Frame shift register (10 bits) on accept: {stop=1, parity=~^tx_data, tx_data}. Data goes out LSB first.
- States:
  - IDLE: oe both 0. On accept, latch frame, counter=0, go to INHIBIT.
  - INHIBIT: `ps2_clk_oe`=1. After INHIBIT_CYCLES cycles, go to RTS.
  - RTS: one cycle with `ps2_clk_oe`=1, `ps2_dat_oe`=1 (start bit 0). Then release the clock (`ps2_clk_oe`=0), hold data low, clear the bit counter, go to SHIFT.
  - SHIFT: on each `fall`, drive the next frame bit: `ps2_dat_oe` = ~bit. The 10th `fall` outputs stop = release. Then go to ACK.
  - ACK: on the next `fall` (the 11th), sample synced data. If 0, go to WAIT_IDLE with ack_ok=1. If 1, go to WAIT_IDLE with ack_ok=0.
  - WAIT_IDLE: wait until synced clk=1 and dat=1. Then pulse `tx_done` (ack_ok) or `tx_err` (!ack_ok), and return to IDLE.
- Timeout counter runs in SHIFT, ACK and WAIT_IDLE. It is cleared on every `fall` and on entry to SHIFT. If it reaches TIMEOUT_CYCLES: release both lines, pulse `tx_err`, go to IDLE.
- `tx_valid` while busy is ignored. No queueing.
- `tx_done` and `tx_err` are never high in the same cycle.
- Counter widths: $clog2 of the respective parameter plus 1. The bit counter is 4 bits.

## Timing
- Reset values: `ps2_clk_oe`=0, `ps2_dat_oe`=0, `tx_ready`=1, `busy`=0, `tx_done`=0, `tx_err`=0, state IDLE.
- Reset asserted mid-frame releases both lines immediately (asynchronously). This forces IDLE with no `tx_err` pulse.
- Accept cycle N: `ps2_clk_oe`=1 at N+1. `ps2_dat_oe`=1 at N+1+INHIBIT_CYCLES. `ps2_clk_oe`=0 one cycle later.
- Pad falling edge to `ps2_dat_oe` update: 3 CLK cycles (2 sync + 1 register). This is well inside the device clock-low half period (≥30 µs).
- `tx_done`/`tx_err` pulse falls 1 cycle after both synced lines are high. `tx_ready` rises in the same cycle as the pulse deasserts.
- All outputs are registered.

## Test plan
- Reset: assert RST with PS2 lines high → all oe 0, `tx_ready`=1, `busy`=0. Assert RST mid-SHIFT → both oe drop in the same timestep, no pulses.
- Send 0xED (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000). Device model clocks at 10 µs half-period and drives ACK low → device captures start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. `tx_done` pulses once, `tx_err` stays 0.
- Send 0x00 → parity bit 1. Send 0xFF → parity bit 0. Both end with `tx_done`.
- Device withholds ACK (data stays high on the 11th edge) → `tx_err` pulses once after lines idle, `tx_done`=0.
- Device stops clocking after 4 bits → after 2000 cycles both oe=0, `tx_err` pulses, IDLE.
- `tx_valid` held with 0x55 during an active 0xED frame → only 0xED is transmitted. 0x55 is accepted only when `tx_ready` returns to 1.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Command/status and open-drain pad bundle between the PS/2 host transmitter
// and its surroundings (command source plus the PS2_CLK/PS2_DAT pad logic).
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    // The environment: command source and the raw pad levels.
    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
        input  tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_err
    );

    // The transmitter itself.
    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
        output tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts
// one odd-parity frame on device clock falls and checks the device acknowledge.
module ps2_host_tx #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ps2_host_tx_if.slave bus
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    if (CLK_HZ <= 0 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("ps2_host_tx: CLK_HZ, INHIBIT_CYCLES and TIMEOUT_CYCLES must be positive");
    end

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_e;

    // ------------------------------------------------------------------
    // Pad synchronizers and device clock fall detection
    // ------------------------------------------------------------------
    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;
    logic       clk_s;
    logic       dat_s;
    logic       fall;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of block evaluation order.
    // Synchronizers reset to the idle-high bus level so leaving reset never
    // fakes a clock fall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], bus.ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], bus.ps2_dat_in};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign fall  = clk_prev_q & ~clk_s;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_e             state_q,   state_d;
    logic [9:0]         frame_q,   frame_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]    to_cnt_q,  to_cnt_d;
    logic               ack_ok_q,  ack_ok_d;
    logic               clk_oe_q,  clk_oe_d;
    logic               dat_oe_q,  dat_oe_d;
    logic               done_q,    done_d;
    logic               err_q,     err_d;
    logic               ready_q,   ready_d;
    logic               busy_q,    busy_d;
    logic               watchdog_on;

    assign watchdog_on = (state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_IDLE);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        ack_ok_d  = ack_ok_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (bus.tx_valid && ready_q) begin
                    frame_d   = {1'b1, ~^bus.tx_data, bus.tx_data};
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
                end
            end

            INHIBIT: begin
                inh_cnt_d = inh_cnt_q + INH_W'(1);
                if (inh_cnt_q == INH_LAST) begin
                    dat_oe_d = 1'b1;
                    state_d  = RTS;
                end
            end

            // Start bit stays on the data line while the clock is handed back.
            RTS: begin
                clk_oe_d  = 1'b0;
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                state_d   = SHIFT;
            end

            SHIFT: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (fall) begin
                    to_cnt_d  = '0;
                    dat_oe_d  = ~frame_q[0];
                    frame_d   = {1'b1, frame_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ACK;
                    end
                end
            end

            ACK: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (fall) begin
                    to_cnt_d = '0;
                    ack_ok_d = ~dat_s;
                    state_d  = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                to_cnt_d = fall ? '0 : to_cnt_q + TO_W'(1);
                if (clk_s && dat_s) begin
                    done_d  = ack_ok_q;
                    err_d   = ~ack_ok_q;
                    state_d = IDLE;
                end
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        // A silent device aborts the frame; this overrides any completion.
        if (watchdog_on && !fall && (to_cnt_q == TO_LAST)) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b1;
            state_d  = IDLE;
        end

        // Ready waits out the status pulse so it rises as the pulse falls.
        ready_d = (state_d == IDLE) && !done_d && !err_d;
        busy_d  = ~ready_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            frame_q   <= '1;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            ack_ok_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            ack_ok_q  <= ack_ok_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.tx_ready   = ready_q;
    assign bus.busy       = busy_q;
    assign bus.ps2_clk_oe = clk_oe_q;
    assign bus.ps2_dat_oe = dat_oe_q;
    assign bus.tx_done    = done_q;
    assign bus.tx_err     = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on an open-drain bus captures each
// frame and compares it with the frame queued when the byte was accepted.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INHIBIT  = 20;
    localparam int TIMEOUT  = 2000;
    localparam int CLK_NS   = 100;
    localparam int HALF_NS  = 10_000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    ps2_host_tx_if bus();

    // Open-drain wired-AND: either side pulling low wins.
    assign bus.ps2_clk_in = ~(bus.ps2_clk_oe | dev_clk_low);
    assign bus.ps2_dat_in = ~(bus.ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .CLK_HZ        (10_000_000),
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #(CLK_NS/2) clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected line-level frame {stop, parity, data, start} per accept.
    logic [10:0] exp_q[$];
    int accepts = 0;

    always @(posedge clk) begin
        if (!rst && bus.tx_valid && bus.tx_ready) begin
            exp_q.push_back({1'b1, ~^bus.tx_data, bus.tx_data, 1'b0});
            accepts++;
        end
    end

    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (bus.tx_done) done_cnt++;
        if (bus.tx_err)  err_cnt++;
        if (bus.tx_done && bus.tx_err) both_cnt++;
    end

    time last_fall  = 0;
    time pulse_time = 0;

    // Device: waits for request-to-send, clocks nbits bits, optionally acknowledges.
    task automatic device_rx(input int nbits, input bit do_ack);
        logic [10:0] cap;
        logic [10:0] mask;
        logic [10:0] exp;
        int guard;
        cap   = '0;
        guard = 0;
        while (!(bus.ps2_clk_in === 1'b1 && bus.ps2_dat_in === 1'b0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("dev_rts_seen", guard < 200, 1);
        if (guard >= 200) return;
        #(HALF_NS);
        cap[0] = bus.ps2_dat_in;
        for (int k = 1; k <= nbits; k++) begin
            dev_clk_low = 1'b1;
            last_fall   = $time;
            #(HALF_NS);
            dev_clk_low = 1'b0;
            cap[k]      = bus.ps2_dat_in;
            #(HALF_NS);
        end
        mask = 11'((1 << (nbits + 1)) - 1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("frame_bits", cap & mask, exp & mask);
        end else begin
            check("sb_has_entry", exp_q.size(), 1);
        end
        if (nbits < 10) return;
        #(HALF_NS/2);
        dev_dat_low = do_ack;
        #(HALF_NS/2);
        dev_clk_low = 1'b1;
        #(HALF_NS);
        dev_clk_low = 1'b0;
        #(HALF_NS/2);
        dev_dat_low = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b, output bit ok);
        int g;
        g = 0;
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        while (bus.tx_ready !== 1'b1 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        ok = (g < 5000);
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.tx_done || bus.tx_err) begin
                seen       = 1'b1;
                pulse_time = $time;
                break;
            end
        end
        check("pulse_seen", seen, 1);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack);
        bit ok;
        bit seen;
        int k;
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        fork
            device_rx(10, ack);
            begin
                drive_byte(b, ok);
                check("accepted", ok, 1);
                check("inh_clk_oe", bus.ps2_clk_oe, 1);
                check("inh_dat_oe", bus.ps2_dat_oe, 0);
                check("inh_busy", bus.busy, 1);
                check("inh_ready", bus.tx_ready, 0);
                k = 0;
                while (!bus.ps2_dat_oe && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                check("inhibit_len", k, INHIBIT);
                check("rts_clk_oe", bus.ps2_clk_oe, 1);
                @(negedge clk);
                check("shift_clk_released", bus.ps2_clk_oe, 0);
                check("start_bit_low", bus.ps2_dat_oe, 1);
                wait_pulse(6000, seen);
                if (seen) begin
                    check("pulse_ready_low", bus.tx_ready, 0);
                    @(negedge clk);
                    check("pulse_one_cycle", bus.tx_done | bus.tx_err, 0);
                    check("ready_back", bus.tx_ready, 1);
                    check("busy_back", bus.busy, 0);
                end
            end
        join
        check("done_count", done_cnt - d0, ack ? 1 : 0);
        check("err_count", err_cnt - e0, ack ? 0 : 1);
    endtask

    initial begin
        bit ok;
        bit seen;
        int d0;
        int e0;
        int a0;
        int g;
        longint elapsed;

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;

        // Reset with idle lines
        repeat (3) @(negedge clk);
        check("rst_clk_oe", bus.ps2_clk_oe, 0);
        check("rst_dat_oe", bus.ps2_dat_oe, 0);
        check("rst_ready", bus.tx_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.tx_done, 0);
        check("rst_err", bus.tx_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_ready", bus.tx_ready, 1);

        // Normal frames with ACK, then a withheld ACK
        run_frame(8'hED, 1'b1);
        run_frame(8'h00, 1'b1);
        run_frame(8'hFF, 1'b1);
        run_frame(8'hA5, 1'b0);

        // Device stops clocking after 4 bits
        d0 = done_cnt;
        e0 = err_cnt;
        fork
            device_rx(4, 1'b1);
            drive_byte(8'h00, ok);
        join
        check("stall_accepted", ok, 1);
        check("stall_dat_held", bus.ps2_dat_oe, 1);
        wait_pulse(TIMEOUT + 500, seen);
        elapsed = longint'((pulse_time - last_fall) / CLK_NS);
        check("stall_latency_min", elapsed >= TIMEOUT, 1);
        check("stall_latency_max", elapsed <= TIMEOUT + 6, 1);
        check("stall_clk_oe", bus.ps2_clk_oe, 0);
        check("stall_dat_oe", bus.ps2_dat_oe, 0);
        @(negedge clk);
        check("stall_ready", bus.tx_ready, 1);
        check("stall_err_count", err_cnt - e0, 1);
        check("stall_done_count", done_cnt - d0, 0);

        // tx_valid held with a new byte during an active frame
        d0 = done_cnt;
        a0 = accepts;
        fork
            begin
                device_rx(10, 1'b1);
                device_rx(10, 1'b1);
            end
            begin
                @(negedge clk);
                bus.tx_data  = 8'hED;
                bus.tx_valid = 1'b1;
                g = 0;
                while (bus.tx_ready !== 1'b1 && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                @(negedge clk);
                bus.tx_data = 8'h55;
                wait_pulse(6000, seen);
                check("held_first_done", bus.tx_done, 1);
                check("held_single_accept", accepts - a0, 1);
                g = 0;
                while ((accepts - a0) < 2 && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                bus.tx_valid = 1'b0;
                check("held_second_accept", accepts - a0, 2);
                check("held_accept_latency", g, 2);
                wait_pulse(6000, seen);
                check("held_second_done", bus.tx_done, 1);
            end
        join
        @(negedge clk);
        check("held_done_count", done_cnt - d0, 2);

        // Reset asserted mid-SHIFT
        fork
            device_rx(3, 1'b1);
            drive_byte(8'h00, ok);
        join
        @(negedge clk);
        check("midrst_dat_oe_before", bus.ps2_dat_oe, 1);
        d0 = done_cnt;
        e0 = err_cnt;
        #7;
        rst = 1'b1;
        #1;
        check("midrst_dat_oe", bus.ps2_dat_oe, 0);
        check("midrst_clk_oe", bus.ps2_clk_oe, 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_no_err", err_cnt - e0, 0);
        check("midrst_ready", bus.tx_ready, 1);
        check("midrst_busy", bus.busy, 0);

        check("sb_drained", exp_q.size(), 0);
        check("no_done_err_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
